// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and defaults for the data-memory responder
// FSM state encoding, default widths and wait-state counter width.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - word storage for the data-memory responder
// Synchronous write, combinational read, contents not reset.
module mem_word_array #(
  parameter int DEPTH = 1024,
  parameter int DW    = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [DW-1:0]    i_wdata,
  output logic [DW-1:0]    o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder16.sv
// rtl/mem_responder16.sv - wait-state data-memory responder for the 16-bit core
// Latches a request, waits WAIT_CYC cycles, accesses the array, pulses ready/err.
module mem_responder16
  import mem_resp_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rdata,
  input  logic          i_wdata,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_datain,
  output logic [DW-1:0] o_dataout,
  output logic          o_ready,
  output logic          o_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_addr;
  logic [DW-1:0]    r_wdat;
  logic             r_wr;
  logic             r_err;
  logic [DW-1:0]    r_dataout;

  logic             w_req;
  logic             w_in_err;
  logic             w_access;
  logic [IDX_W-1:0] w_acc_addr;
  logic [DW-1:0]    w_acc_data;
  logic             w_acc_wr;
  logic             w_acc_err;
  logic             w_we;
  logic [DW-1:0]    w_rd;

  assign w_req    = i_rdata | i_wdata;
  assign w_in_err = ({1'b0, i_addr} >= DEPTH_L) | (i_rdata & i_wdata);

  // With zero wait states the access uses the live request, not the latch.
  always_comb begin
    w_next_state = r_state;
    w_access     = 1'b0;
    w_acc_addr   = r_addr;
    w_acc_data   = r_wdat;
    w_acc_wr     = r_wr;
    w_acc_err    = r_err;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (WAIT_CYC == 0) begin
            w_next_state = ST_DONE;
            w_access     = 1'b1;
            w_acc_addr   = i_addr[IDX_W-1:0];
            w_acc_data   = i_datain;
            w_acc_wr     = i_wdata;
            w_acc_err    = w_in_err;
          end else begin
            w_next_state = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_next_state = ST_DONE;
          w_access     = 1'b1;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Reset on the commit edge must discard the pending write.
  assign w_we = w_access & w_acc_wr & ~w_acc_err & ~i_rst;

  mem_word_array #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .IDX_W (IDX_W)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_addr  (w_acc_addr),
    .i_wdata (w_acc_data),
    .o_rdata (w_rd)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdat    <= '0;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_dataout <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && w_req) begin
        r_addr <= i_addr[IDX_W-1:0];
        r_wdat <= i_datain;
        r_wr   <= i_wdata;
        r_err  <= w_in_err;
        r_cnt  <= CNT_W'(WAIT_CYC);
      end else if (r_state == ST_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_access && !w_acc_wr && !w_acc_err) begin
        r_dataout <= w_rd;
      end
    end
  end

  assign o_ready   = (r_state == ST_DONE);
  assign o_err     = (r_state == ST_DONE) & r_err;
  assign o_dataout = r_dataout;

endmodule

// File: tb/tb_mem_responder16.sv
// tb/tb_mem_responder16.sv - directed self-checking bench for mem_responder16
// Two instances: WAIT_CYC=2 and WAIT_CYC=0, sharing clock and reset.
module tb_mem_responder16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd2, wr2, rd0, wr0;
  logic [15:0] a2, d2, a0, d0;
  logic [15:0] q2, q0;
  logic        rdy2, e2, rdy0, e0;

  bit          sel;
  logic [15:0] q;
  logic        rdy, er;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_responder16 #(.DW(16), .AW(16), .DEPTH(1024), .WAIT_CYC(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_rdata(rd2), .i_wdata(wr2), .i_addr(a2),
    .i_datain(d2), .o_dataout(q2), .o_ready(rdy2), .o_err(e2)
  );

  mem_responder16 #(.DW(16), .AW(16), .DEPTH(1024), .WAIT_CYC(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_rdata(rd0), .i_wdata(wr0), .i_addr(a0),
    .i_datain(d0), .o_dataout(q0), .o_ready(rdy0), .o_err(e0)
  );

  always_comb begin
    q   = sel ? q0 : q2;
    rdy = sel ? rdy0 : rdy2;
    er  = sel ? e0 : e2;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (s) begin
      rd0 = r; wr0 = w; a0 = a; d0 = d;
    end else begin
      rd2 = r; wr2 = w; a2 = a; d2 = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction; scr scrambles addr/data right after capture.
  task automatic txn(input bit s, input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic exp_err, input bit chk_q, input logic [15:0] exp_q,
                     input bit scr, input string tag);
    int lat;
    sel = s;
    drive(s, r, w, a, d);
    step();
    drive(s, 1'b0, 1'b0, scr ? ~a : a, scr ? ~d : d);
    lat = 0;
    while (rdy !== 1'b1 && lat < 12) begin
      chk({tag, "_err_idle"}, {15'd0, er}, 16'd0);
      step();
      lat++;
    end
    chk({tag, "_lat"}, 16'(lat), s ? 16'd0 : 16'd2);
    chk({tag, "_err"}, {15'd0, er}, {15'd0, exp_err});
    if (chk_q) chk({tag, "_data"}, q, exp_q);
    step();
    chk({tag, "_rdy_low"}, {15'd0, rdy}, 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_rdy2", {15'd0, rdy2}, 16'd0);
      chk("rst_err2", {15'd0, e2}, 16'd0);
      chk("rst_q2", q2, 16'h0000);
      chk("rst_rdy0", {15'd0, rdy0}, 16'd0);
      chk("rst_q0", q0, 16'h0000);
    end

    txn(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 1'b0, "w10");
    txn(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, "r10");

    txn(1'b1, 1'b0, 1'b1, 16'h0001, 16'hA001, 1'b0, 1'b0, 16'h0000, 1'b0, "z_w1");
    txn(1'b1, 1'b0, 1'b1, 16'h0002, 16'hA002, 1'b0, 1'b0, 16'h0000, 1'b0, "z_w2");
    txn(1'b1, 1'b0, 1'b1, 16'h0003, 16'hA003, 1'b0, 1'b0, 16'h0000, 1'b0, "z_w3");
    sel = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000);
    step();
    chk("b2b_rdy1", {15'd0, rdy0}, 16'd1);
    chk("b2b_q1", q0, 16'hA001);
    drive(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
    step();
    chk("b2b_gap1", {15'd0, rdy0}, 16'd0);
    step();
    chk("b2b_rdy2", {15'd0, rdy0}, 16'd1);
    chk("b2b_q2", q0, 16'hA002);
    drive(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000);
    step();
    chk("b2b_gap2", {15'd0, rdy0}, 16'd0);
    step();
    chk("b2b_rdy3", {15'd0, rdy0}, 16'd1);
    chk("b2b_q3", q0, 16'hA003);
    chk("b2b_err3", {15'd0, e0}, 16'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("b2b_end1", {15'd0, rdy0}, 16'd0);
    step();
    chk("b2b_end2", {15'd0, rdy0}, 16'd0);

    txn(1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0, "oor");
    txn(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0, "oor_max");
    txn(1'b0, 1'b1, 1'b1, 16'h0010, 16'h5555, 1'b1, 1'b1, 16'hBEEF, 1'b0, "both");
    txn(1'b0, 1'b1, 1'b0, 16'h03FF, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, "top_ok");
    txn(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, "r10_after");

    txn(1'b0, 1'b0, 1'b1, 16'h0005, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 1'b0, "w5_old");
    sel = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 16'h0005, 16'h1234);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h0005, 16'h1234);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_rdy", {15'd0, rdy2}, 16'd0);
    chk("abort_q", q2, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_quiet", {15'd0, rdy2}, 16'd0);
    end
    txn(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 1'b0, "r5");

    txn(1'b0, 1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b1, "w20_scr");
    txn(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h1111, 1'b1, "r20_scr");
    txn(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, "r10_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
